// File: rtl/data_sram_responder.sv
// Data SRAM responder: word-organised memory with byte-lane stores, a fixed
// response latency and a small in-order FIFO of pending responses.
module data_sram_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2,
  parameter int DEPTH      = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        misalign
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [1:0] CD_INIT = 2'(LATENCY - 1);

  logic [31:0] mem [0:(1 << ADDR_WIDTH) - 1];

  logic [31:0] fifo_rdata [DEPTH];
  logic        fifo_mis   [DEPTH];
  logic [1:0]  fifo_cd    [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;

  logic [ADDR_WIDTH-1:0] word_idx;
  logic [3:0]  byte_en;
  logic        req_mis;
  logic        accept;
  logic        pop;
  logic [31:0] load_word;
  logic        unused_addr_bits;

  // Upper address bits alias onto the same words and are deliberately dropped.
  assign unused_addr_bits = ^data_addr[31:ADDR_WIDTH+2];
  assign word_idx = data_addr[ADDR_WIDTH+1:2];

  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Decode byte lanes and flag misaligned or illegal-size requests.
  always_comb begin
    byte_en = 4'b0000;
    req_mis = 1'b0;
    case (data_size)
      2'b00: byte_en = 4'b0001 << data_addr[1:0];
      2'b01: begin
        byte_en = data_addr[1] ? 4'b1100 : 4'b0011;
        req_mis = data_addr[0];
      end
      2'b10: begin
        byte_en = 4'b1111;
        req_mis = (data_addr[1:0] != 2'b00);
      end
      default: req_mis = 1'b1;
    endcase
  end

  // Acceptance uses only the registered count, so a pop never frees a slot
  // in the same cycle; responses are never back-pressured.
  assign data_addr_ok = rst & (count < CNT_W'(DEPTH));
  assign accept       = data_req & data_addr_ok;
  assign data_data_ok = rst & (count != '0) & (fifo_cd[head] == 2'd0);
  assign pop          = data_data_ok;
  assign data_rdata   = data_data_ok ? fifo_rdata[head] : 32'h0;
  assign misalign     = data_data_ok & fifo_mis[head];
  assign load_word    = (data_wr || req_mis) ? 32'h0 : mem[word_idx];

  // Store path: enabled byte lanes are written at the acceptance edge; the
  // array is intentionally left out of reset so contents survive it.
  always_ff @(posedge clk) begin
    if (accept && data_wr && !req_mis) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) mem[word_idx][8*b +: 8] <= data_wdata[8*b +: 8];
      end
    end
  end

  // Response FIFO: push on accept, age every entry, pop when the head expires.
  always_ff @(posedge clk) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (fifo_cd[i] != 2'd0) fifo_cd[i] <= fifo_cd[i] - 2'd1;
      end
      if (accept) begin
        fifo_rdata[tail] <= load_word;
        fifo_mis[tail]   <= req_mis;
        fifo_cd[tail]    <= CD_INIT;
        tail             <= bump(tail);
      end
      if (pop) head <= bump(head);
      case ({accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule
